// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the pipelined RV32 core.
//
// Owns the PC and keeps at most one request in flight to instruction memory.
// It loads the IF/ID pipeline register from the memory response (or from the
// hold buffer), and inserts bubbles on empty cycles and on redirects.
//
// Ports:
//   clk, rst_n          core clock (rising edge), asynchronous active-low reset
//   stall               hazard-unit hold: freezes the PC and IF/ID
//   redirect            taken branch/jump from EX; flushes IF/ID
//   redirect_pc[31:0]   new fetch address (bits [1:0] are forced to 0)
//   imem_req            one-cycle request strobe
//   imem_addr[31:0]     request address, meaningful while imem_req=1
//   imem_rdata[31:0]    response instruction, meaningful with imem_rvalid
//   imem_rvalid         response strobe
//   if_id_pc/instr/valid  IF/ID pipeline register
//   dbg_state_o[1:0]    current fetch FSM state (ISSUE=0, WAIT=1, HOLD=2, DROP=3)
//
// Optional build macro FETCH_PERF_CNT_EN adds the following outputs:
//   perf_stall_cycles[31:0]  cycles with stall=1 and redirect=0
//   perf_flush_count[31:0]   cycles with redirect=1
//
// Memory handshake: imem_req is a single-cycle strobe issued only from ISSUE.
// Exactly one imem_rvalid pulse answers it, at least one cycle later.
// No new request is issued until that response has been consumed (WAIT),
// parked (HOLD) or thrown away (DROP). The memory has no ready signal. An
// imem_rvalid seen while nothing is outstanding (ISSUE/HOLD) is ignored.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [1:0]  dbg_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        resp_ok;
  logic        deliver;
  logic [1:0]  unused_pc_bits;

  assign unused_pc_bits = redirect_pc[1:0];

  // A response counts only while WAIT is expecting one.
  assign resp_ok = (state_q == ST_WAIT) && imem_rvalid;
  // An instruction reaches IF/ID only when neither redirect nor stall blocks it.
  assign deliver = !redirect && !stall &&
                   (resp_ok || (state_q == ST_HOLD));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: state_d = redirect ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (redirect) begin
          // Response already here: discard it now; else drop it when it lands.
          state_d = imem_rvalid ? ST_ISSUE : ST_DROP;
        end else if (imem_rvalid) begin
          state_d = stall ? ST_HOLD : ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) state_d = ST_ISSUE;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = (state_q == ST_ISSUE) && rst_n;
    imem_addr   = pc_q;
    dbg_state_o = state_q;
  end

  // PC, hold buffer and IF/ID next values
  always_comb begin
    pc_d          = pc_q;
    hold_d        = hold_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (deliver) begin
      pc_d = pc_q + 32'd4;
    end

    // Response arrives under stall: park it until the stall lifts.
    if (resp_ok && stall && !redirect) begin
      hold_d = imem_rdata;
    end

    if (redirect) begin
      if_id_pc_d    = 32'h0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      // IF/ID holds its current contents.
    end else if (deliver) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = (state_q == ST_HOLD) ? hold_q : imem_rdata;
      if_id_valid_d = 1'b1;
    end else begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      hold_q        <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      hold_q        <= hold_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall && !redirect) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect)           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- randomized bench for fetch_stage.
// Inputs are driven and outputs are compared on the falling edge. A
// variable-latency memory answers each request. A transaction-level reference
// model (outstanding / discard / held flags) predicts the stage's outputs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .dbg_state_o (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_pc, m_hold, m_ifid_pc, m_ifid_instr;
  logic        m_out, m_disc, m_held, m_ifid_valid;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  // Memory model state
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat;

  // Scoreboard queue: addresses the model expects to fetch, in order.
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h0010_8113;
      32'h8: return 32'h00A0_0193;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_hold = 32'h0;
    m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0;
    m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    exp_q.delete();
  endtask

  // One clock of the reference model, using the inputs now on the pins.
  task automatic model_step();
    logic        req, delivered;
    logic [31:0] instr;
    req = !m_out && !m_held;
    if (req) exp_q.push_back(m_pc);
    if (stall && !redirect) m_stall_cnt = m_stall_cnt + 1;
    if (redirect)           m_flush_cnt = m_flush_cnt + 1;
    if (redirect) begin
      m_out  = req || (m_out && !imem_rvalid);
      m_disc = m_out;
      m_held = 1'b0;
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
      m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    end else begin
      delivered = 1'b0;
      instr = NOP;
      if (m_out && imem_rvalid) begin
        m_out = 1'b0;
        if (!m_disc) begin
          if (stall) begin
            m_held = 1'b1; m_hold = imem_rdata;
          end else begin
            delivered = 1'b1; instr = imem_rdata;
          end
        end
      end else if (m_held && !stall) begin
        delivered = 1'b1; instr = m_hold; m_held = 1'b0;
      end
      if (req) begin
        m_out = 1'b1; m_disc = 1'b0;
      end
      if (!stall) begin
        m_ifid_pc = m_pc;
        m_ifid_instr = instr;
        m_ifid_valid = delivered;
        if (delivered) m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_outputs();
    logic exp_req;
    exp_req = !m_out && !m_held;
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req && imem_req) begin
      chk("imem_addr", imem_addr, m_pc);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    chk("if_id_pc", if_id_pc, m_ifid_pc);
    chk("if_id_instr", if_id_instr, m_ifid_instr);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_ifid_valid});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, m_stall_cnt);
    chk("perf_flush", perf_flush_count, m_flush_cnt);
`endif
  endtask

  // Driver: memory response for this cycle, then random control inputs.
  task automatic drive_cycle(input bit quiet);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend = 1'b0;
      end
    end
    lat = quiet ? 1 : $urandom_range(1, 3);
    if (imem_req) begin
      pend = 1'b1; pend_cnt = lat; pend_addr = imem_addr;
    end
    if (quiet) begin
      stall = 1'b0; redirect = 1'b0;
    end else begin
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 3))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2: redirect_pc = 32'h0000_0100 | 32'($urandom_range(0, 3));
        default: redirect_pc = 32'h0000_0010;
      endcase
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_pc"}, if_id_pc, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    #1;
    // First request after release must target RESET_PC.
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      cyc = i;
      if (i == 1500) begin
        // Asynchronous reset in the middle of traffic.
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("mid_rst");
        stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        #1;
      end
      compare_outputs();
      drive_cycle((i < 20) || (i >= 1500 && i < 1510));
      model_step();
      @(negedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
